// File: rtl/vout_wled_multi.sv
// WS2812 serial driver for a chain of NUM_LEDS pixels; frames repeat back-to-back after each latch.
// Optional macro VOUT_WLED_RGBW_EN: send 32-bit G,R,B,W words per LED instead of 24-bit GRB.
module vout_wled_multi #(
  parameter int CLK_MHZ  = 27,
  parameter int NUM_LEDS = 8,
  parameter int RESET_US = 80
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_LEDS*32-1:0] value,
  output logic                   wled,
  output logic                   busy,
  output logic                   frame_done
);
  localparam int T_BIT = CLK_MHZ * 1250 / 1000;
  localparam int T0H   = CLK_MHZ * 400 / 1000;
  localparam int T1H   = CLK_MHZ * 800 / 1000;
  localparam int T_RST = CLK_MHZ * RESET_US;
`ifdef VOUT_WLED_RGBW_EN
  localparam int BPL   = 32;
`else
  localparam int BPL   = 24;
`endif
  localparam int FW    = NUM_LEDS * BPL;
  localparam int PW    = $clog2(FW);
  localparam int CW    = $clog2(((T_RST > T_BIT) ? T_RST : T_BIT) + 1);
  localparam int LW    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int BW    = $clog2(BPL);

  typedef enum logic [1:0] {LATCH, LOAD, HIGH, LOW} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] led_idx;
  logic [BW-1:0] bit_idx;
  logic [FW-1:0] frame;
  logic [FW-1:0] load_frame;
  logic [PW-1:0] bit_pos;
  logic [CW-1:0] t_high;
  logic          cur_bit;
  logic          last_bit;

  // Each LED occupies BPL frame bits, highest bit transmitted first.
  always_comb begin
    load_frame = '0;
    for (int n = 0; n < NUM_LEDS; n++) begin
`ifdef VOUT_WLED_RGBW_EN
      load_frame[n*BPL +: BPL] = {value[n*32 +: 24], value[n*32+24 +: 8]};
`else
      load_frame[n*BPL +: BPL] = value[n*32 +: 24];
`endif
    end
  end

`ifndef VOUT_WLED_RGBW_EN
  logic unused_w;
  always_comb begin
    unused_w = 1'b0;
    for (int n = 0; n < NUM_LEDS; n++) unused_w = unused_w ^ (^value[n*32+24 +: 8]);
  end
`endif

  assign bit_pos  = PW'(led_idx) * PW'(BPL) + PW'(bit_idx);
  assign cur_bit  = frame[bit_pos];
  assign t_high   = cur_bit ? CW'(T1H - 1) : CW'(T0H - 1);
  assign last_bit = (led_idx == LW'(NUM_LEDS - 1)) && (bit_idx == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LATCH;
      cnt        <= '0;
      led_idx    <= '0;
      bit_idx    <= '0;
      frame      <= '0;
      wled       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        LATCH: begin
          if (cnt == CW'(T_RST - 1)) begin
            state <= LOAD;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            cnt        <= cnt + CW'(1);
            // registered pulse lands on the final latch cycle
            frame_done <= (cnt == CW'(T_RST - 2));
          end
        end
        LOAD: begin
          frame   <= load_frame;
          led_idx <= '0;
          bit_idx <= BW'(BPL - 1);
          cnt     <= '0;
          wled    <= 1'b1;
          state   <= HIGH;
        end
        HIGH: begin
          cnt <= cnt + CW'(1);
          if (cnt == t_high) begin
            wled  <= 1'b0;
            state <= LOW;
          end
        end
        LOW: begin
          if (cnt == CW'(T_BIT - 1)) begin
            cnt <= '0;
            if (last_bit) begin
              state <= LATCH;
              busy  <= 1'b0;
            end else begin
              state <= HIGH;
              wled  <= 1'b1;
              if (bit_idx == '0) begin
                bit_idx <= BW'(BPL - 1);
                led_idx <= led_idx + LW'(1);
              end else begin
                bit_idx <= bit_idx - BW'(1);
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= LATCH;
      endcase
    end
  end
endmodule

// File: tb/tb_vout_wled_multi.sv
// Bench for vout_wled_multi: cycle-exact reference model, table of frame patterns, reset corner cases.
`timescale 1ns/1ps
module tb_vout_wled_multi;
  localparam int CLK_MHZ  = 27;
  localparam int NUM_LEDS = 2;
  localparam int RESET_US = 80;
  localparam int T_BIT    = CLK_MHZ * 1250 / 1000;
  localparam int T0H      = CLK_MHZ * 400 / 1000;
  localparam int T1H      = CLK_MHZ * 800 / 1000;
  localparam int T_RST    = CLK_MHZ * RESET_US;
`ifdef VOUT_WLED_RGBW_EN
  localparam int BPL      = 32;
`else
  localparam int BPL      = 24;
`endif
  localparam int NB       = NUM_LEDS * BPL;
  localparam int PERIOD   = T_RST + 1 + NB * T_BIT;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_LEDS*32-1:0] value = '0;
  logic                   wled, busy, frame_done;

  int checks = 0;
  int errors = 0;

  vout_wled_multi #(.CLK_MHZ(CLK_MHZ), .NUM_LEDS(NUM_LEDS), .RESET_US(RESET_US)) dut (
    .clk(clk), .rst(rst), .value(value), .wled(wled), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // k-th transmitted bit of a frame: LED 0 first, G7..G0 R7..R0 B7..B0 (W7..W0).
  function automatic int frame_bit(input logic [NUM_LEDS*32-1:0] v, input int k);
    logic [31:0] w;
    int led, pos;
    led = k / BPL;
    pos = k % BPL;
    w   = v[led*32 +: 32];
    if (pos < 24) return int'(w[23-pos]);
    return int'(w[55-pos]);
  endfunction

  // Reference model: position inside the frame period since reset release.
  int t = 0, frame_cnt = 0, hi_acc = 0, busy_acc = 0, last_hi = 0, last_busy = 0;
  logic [NUM_LEDS*32-1:0] snap = '0;

  always @(negedge clk) begin : model
    logic ew, eb, ef;
    int p, q, b;
    if (rst) begin
      ew = 1'b0; eb = 1'b0; ef = 1'b0;
      t = 0; hi_acc = 0; busy_acc = 0;
    end else begin
      p = t % PERIOD;
      t++;
      if (p < T_RST) begin
        ew = 1'b0; eb = 1'b0; ef = (p == T_RST - 1);
      end else if (p == T_RST) begin
        ew = 1'b0; eb = 1'b1; ef = 1'b0;
        snap = value;
      end else begin
        q  = p - T_RST - 1;
        b  = frame_bit(snap, q / T_BIT);
        ew = (q % T_BIT) < ((b != 0) ? T1H : T0H);
        eb = 1'b1; ef = 1'b0;
      end
    end
    checks++;
    if ({wled, busy, frame_done} !== {ew, eb, ef}) begin
      errors++;
      $display("FAIL cycle_model t=%0d rst=%b got wled/busy/done=%b%b%b required %b%b%b",
               t, rst, wled, busy, frame_done, ew, eb, ef);
    end
    if (!rst) begin
      hi_acc   += int'(wled);
      busy_acc += int'(busy);
      if (frame_done) begin
        last_hi = hi_acc; last_busy = busy_acc;
        hi_acc = 0; busy_acc = 0;
        frame_cnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fd();
    int s, n;
    s = frame_cnt;
    n = 0;
    while (frame_cnt == s && n < PERIOD + 100) begin
      step(1);
      n++;
    end
    checks++;
    if (frame_cnt == s) begin
      errors++;
      $display("FAIL frame_timeout waited %0d cycles required frame_done within %0d", n, PERIOD + 100);
    end
  endtask

  // Release reset and count cycles until the first rising data edge.
  task automatic release_and_time(input string name);
    int n;
    step(1);
    rst = 1'b0;
    n = 0;
    while (!wled && n < PERIOD) begin
      step(1);
      n++;
    end
    checks++;
    if (n != T_RST + 1) begin
      errors++;
      $display("FAIL %s first_edge got %0d cycles required %0d", name, n, T_RST + 1);
    end
  endtask

  task automatic reset_mid_high(input int delay);
    int n;
    step(delay);
    n = 0;
    while (!wled && n < PERIOD) begin
      step(1);
      n++;
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({wled, busy, frame_done} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset got wled/busy/done=%b%b%b required 000", wled, busy, frame_done);
    end
    step(2);
    release_and_time("after_mid_reset");
  endtask

  typedef struct {
    logic [31:0] v0;
    logic [31:0] v1;
    int          ones;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{32'h0080_0000, 32'h0000_0000, 1};
    tbl[1] = '{32'h00FF_FFFF, 32'h0000_0000, 24};
    tbl[4] = '{32'h0000_0000, 32'h0000_0001, 1};
`ifdef VOUT_WLED_RGBW_EN
    tbl[2] = '{32'hA500_0000, 32'h0000_0000, 4};
    tbl[3] = '{32'h1234_5678, 32'hFF0F_00F0, 29};
`else
    tbl[2] = '{32'hA500_0000, 32'h0000_0000, 0};
    tbl[3] = '{32'h1234_5678, 32'hFF0F_00F0, 19};
`endif

    step(3);
    release_and_time("power_on");
    wait_fd();

    // Each entry is loaded in the LOAD cycle; value is scrambled after bit 5.
    for (int i = 0; i < 5; i++) begin
      int exp_hi, exp_busy;
      value = {tbl[i].v1, tbl[i].v0};
      step(1 + 6 * T_BIT + 3);
      value = ~value;
      wait_fd();
      exp_hi   = tbl[i].ones * T1H + (NB - tbl[i].ones) * T0H;
      exp_busy = 1 + NB * T_BIT;
      checks++;
      if (last_hi != exp_hi) begin
        errors++;
        $display("FAIL vec%0d high_cycles got %0d required %0d", i, last_hi, exp_hi);
      end
      checks++;
      if (last_busy != exp_busy) begin
        errors++;
        $display("FAIL vec%0d busy_cycles got %0d required %0d", i, last_busy, exp_busy);
      end
    end

    // Random value changes at arbitrary cycles, checked cycle by cycle by the model.
    for (int c = 0; c < 3 * PERIOD; c++) begin
      if ($urandom_range(0, 99) == 0) value = {$urandom, $urandom};
      step(1);
    end

    reset_mid_high($urandom_range(0, 300));
    reset_mid_high(T_BIT * 7 + $urandom_range(0, 40));
    wait_fd();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vout_wled_multi.md
VOUT_WLED_MULTI -- requirements
Module: vout_wled_multi

Interface
REQ-001 Parameter CLK_MHZ, default 27: system clock frequency in MHz, used for all timing derivation.
REQ-002 Parameter NUM_LEDS, default 8: LEDs in the chain; legal range 1..64.
REQ-003 Parameter RESET_US, default 80: minimum latch (line-low) time between frames, in µs.
REQ-004 Port clk, input, 1: single system clock; all logic rising-edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port value, input, NUM_LEDS*32: per-LED word; LED n occupies bits [32n+31:32n]; [23:0]=GRB (G in [23:16]); [31:24]=W.
REQ-007 Port wled, output, 1: serial WS2812 data line.
REQ-008 Port busy, output, 1: high while bits are being shifted, low during latch.
REQ-009 Port frame_done, output, 1: one-cycle pulse when the latch period of a frame completes.

Function
REQ-010 Derived cycle counts SHALL use integer division: T_BIT=CLK_MHZ*1250/1000, T0H=CLK_MHZ*400/1000, T1H=CLK_MHZ*800/1000, T_RST=CLK_MHZ*RESET_US.
REQ-011 The state machine SHALL have states LATCH, LOAD, HIGH, LOW; leaving reset it SHALL enter LATCH.
REQ-012 LATCH: wled=0, busy=0, count T_RST cycles; on the last cycle pulse frame_done and go to LOAD.
REQ-013 LOAD (1 cycle): snapshot the entire value bus into an internal frame register, set LED index 0, bit index MSB, go to HIGH.
REQ-014 Changes on value after LOAD SHALL NOT affect the frame in progress.
REQ-015 HIGH: wled=1 for T1H cycles if the current bit is 1, T0H cycles if 0; then go to LOW.
REQ-016 LOW: wled=0 for the remainder of T_BIT, so HIGH+LOW totals exactly T_BIT cycles per bit.
REQ-017 Bits SHALL be sent MSB first per LED, LED 0 first; per-LED order G7..G0, R7..R0, B7..B0.
REQ-018 After the last bit of LED NUM_LEDS-1, LOW SHALL go to LATCH; otherwise it SHALL advance the bit/LED index and go to HIGH.
REQ-019 Frames SHALL repeat continuously, with no idle gap beyond LATCH and the one-cycle LOAD.
REQ-020 busy SHALL be 1 from LOAD through the final LOW cycle inclusive.
REQ-021 NUM_LEDS=1 SHALL work with no index wrap errors; LED index width is clog2(NUM_LEDS), minimum 1.

Reset
REQ-022 On rst assertion, regardless of state (including mid-bit), wled, busy and frame_done SHALL go to 0 asynchronously.
REQ-023 While rst is asserted, state=LATCH, all counters=0 and the frame register=0.
REQ-024 After rst deassertion, a full T_RST latch SHALL precede the first bit.

Configuration
REQ-025 Macro VOUT_WLED_RGBW_EN: when defined, each LED word SHALL be 32 bits sent G,R,B,W, with W taken from value[31:24].
REQ-026 Without VOUT_WLED_RGBW_EN, 24 bits per LED SHALL be sent, value[31:24] SHALL be ignored, and the frame register SHALL be NUM_LEDS*24 bits.

Verification (CLK_MHZ=27, RESET_US=80: T_BIT=33, T0H=10, T1H=21, T_RST=2160)
REQ-027 Reset, then release, NUM_LEDS=1 -> wled low for 2160 cycles, frame_done pulse, then first rising edge 2 cycles later (LOAD+HIGH entry).
REQ-028 LED0 value=0x00800000 -> first bit high 21 cycles, low 12; remaining 23 bits high 10, low 23; busy high 1+24*33 cycles.
REQ-029 NUM_LEDS=2, LED0=0x00FFFFFF, LED1=0x00000000 -> 24 "1" symbols then 24 "0" symbols, then a 2160-cycle latch.
REQ-030 Change value mid-frame (after bit 5) -> current frame bits unchanged; the next frame reflects the new value.
REQ-031 Assert rst during a HIGH phase -> wled=0 in the same cycle; after release, a full 2160-cycle latch precedes data.
REQ-032 With VOUT_WLED_RGBW_EN, value=0xA5000000 -> 24 zero bits then 10100101; busy length 1+32*33 cycles.
